// File: rtl/tfd_seq_pkg.sv
// tfd_seq_pkg: shared widths, table entry and FSM state types for tfd_sequencer
package tfd_seq_pkg;
  localparam int K_W = 32;
  localparam int DUR_W = 16;
  typedef struct packed {
    logic [K_W-1:0]   k;
    logic [DUR_W-1:0] dur;
  } seq_entry_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} seq_state_t;
endpackage

// File: rtl/tfd_tick_gen.sv
// tfd_tick_gen: prescaler emitting a one-cycle tick every TICK_DIV clocks, restarted by clr_i
module tfd_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q;
  logic          wrap;
  assign wrap   = cnt_q == CW'(TICK_DIV - 1);
  assign tick_o = !clr_i && wrap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= clr_i || wrap ? '0 : cnt_q + CW'(1);
  end
endmodule

// File: rtl/tfd_sequencer.sv
// tfd_sequencer: plays a table of {k, dur} entries into a toggle divider.
// Define TFD_SEQ_LOOP_EN to repeat the sequence until stop instead of finishing with a done pulse.
module tfd_sequencer
  import tfd_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 100000,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [K_W-1:0]   wr_k_i,
  input  logic [DUR_W-1:0] wr_dur_i,
  input  logic [AW:0]      len_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [K_W-1:0]   div_k_o,
  output logic             div_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW:0]      idx_o
);
  seq_entry_t       tbl_q [DEPTH];
  seq_entry_t       cur;
  seq_state_t       state_q;
  logic [K_W-1:0]   div_k_q;
  logic             div_en_q, busy_q, done_q;
  logic [AW:0]      idx_q, len_q, idx_inc;
  logic [DUR_W-1:0] dur_q, ticks_q;
  logic             tick, play_end, at_end, fin;
  tfd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != S_PLAY),
    .tick_o (tick)
  );
  always_ff @(posedge clk) begin
    if (wr_en_i && state_q == S_IDLE) tbl_q[wr_addr_i] <= '{k: wr_k_i, dur: wr_dur_i};
  end
  assign cur      = tbl_q[idx_q[AW-1:0]];
  assign idx_inc  = idx_q + (AW+1)'(1);
  assign play_end = state_q == S_PLAY && tick && ticks_q + DUR_W'(1) == dur_q;
  // A skipped final entry ends the sequence straight from LOAD; len==0 ends on the first LOAD.
  assign at_end   = state_q == S_LOAD ? idx_q == len_q || (cur.dur == '0 && idx_inc == len_q)
                                      : idx_inc == len_q;
  assign fin      = (state_q == S_LOAD || play_end) && at_end;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_k_q  <= '0;
      div_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      len_q    <= '0;
      dur_q    <= '0;
      ticks_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      ticks_q <= state_q == S_PLAY ? ticks_q + DUR_W'(tick) : '0;
      if (stop_i && state_q != S_IDLE) begin
        state_q  <= S_IDLE;
        busy_q   <= 1'b0;
        idx_q    <= '0;
        div_k_q  <= '0;
        div_en_q <= 1'b0;
      end else if (fin) begin
`ifdef TFD_SEQ_LOOP_EN
        state_q <= S_LOAD;
        idx_q   <= '0;
`else
        state_q  <= S_DONE;
        idx_q    <= len_q;
        done_q   <= 1'b1;
        div_k_q  <= '0;
        div_en_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE: if (start_i && !stop_i) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            len_q   <= len_i;
          end
          S_LOAD: if (cur.dur == '0) idx_q <= idx_inc;
          else begin
            state_q  <= S_PLAY;
            div_k_q  <= cur.k;
            div_en_q <= cur.k != '0;
            dur_q    <= cur.dur;
          end
          S_PLAY: if (play_end) begin
            state_q <= S_LOAD;
            idx_q   <= idx_inc;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
  assign div_k_o  = div_k_q;
  assign div_en_o = div_en_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign idx_o    = idx_q;
endmodule

// File: tb/tb_tfd_sequencer.sv
// tb_tfd_sequencer: vector table, hand-written corner sequences and randomized runs against a trace model
module tb_tfd_sequencer;
  localparam int TD    = 4;
  localparam int DEPTH = 4;
`ifdef TFD_SEQ_LOOP_EN
  localparam int LOOPS = 3;
`else
  localparam int LOOPS = 1;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en_i = 1'b0, start_i = 1'b0, stop_i = 1'b0;
  logic [1:0]  wr_addr_i = '0;
  logic [31:0] wr_k_i = '0;
  logic [15:0] wr_dur_i = '0;
  logic [2:0]  len_i = '0;
  logic [31:0] div_k_o;
  logic        div_en_o, busy_o, done_o;
  logic [2:0]  idx_o;
  tfd_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_k_i(wr_k_i),
    .wr_dur_i(wr_dur_i), .len_i(len_i), .start_i(start_i), .stop_i(stop_i),
    .div_k_o(div_k_o), .div_en_o(div_en_o), .busy_o(busy_o), .done_o(done_o), .idx_o(idx_o)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] k; logic en, busy, done; int idx;} obs_t;
  typedef struct {int k0, d0, k1, d1, len, busy_n, done_at, probe_t, probe_k, probe_en;} vec_t;
  obs_t        exp_q[$];
  vec_t        vt[4];
  int unsigned mk[DEPTH];
  int unsigned md[DEPTH];
  int          checks = 0, errors = 0;
  int          bn, da, dn, ln;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input int a, input int unsigned k, input int unsigned d);
    wr_en_i = 1'b1; wr_addr_i = 2'(a); wr_k_i = k; wr_dur_i = 16'(d);
    step();
    wr_en_i = 1'b0;
    mk[a] = k; md[a] = d;
  endtask
  // Expected per-cycle outputs after start: one LOAD cycle per entry holding the previous
  // divider values, dur*TD cycles of that entry, then a done cycle and idle.
  task automatic build(input int len, input int loops);
    logic [31:0] k;
    logic        en;
    k = '0; en = 1'b0;
    exp_q.delete();
    for (int l = 0; l < loops; l++) begin
      if (len == 0) exp_q.push_back('{k, en, 1'b1, 1'b0, 0});
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{k, en, 1'b1, 1'b0, i});
        if (md[i] != 0) begin
          k = mk[i]; en = mk[i] != 0;
          for (int t = 0; t < int'(md[i]) * TD; t++) exp_q.push_back('{k, en, 1'b1, 1'b0, i});
        end
      end
    end
`ifndef TFD_SEQ_LOOP_EN
    exp_q.push_back('{32'd0, 1'b0, 1'b1, 1'b1, -1});
    exp_q.push_back('{32'd0, 1'b0, 1'b0, 1'b0, -1});
`endif
  endtask
  task automatic run(input string nm, input int len, input int wr_at, input bit co_wr,
                     input int ca, input int unsigned ck, input int unsigned cd);
    if (co_wr) begin
      mk[ca] = ck; md[ca] = cd;
      wr_en_i = 1'b1; wr_addr_i = 2'(ca); wr_k_i = ck; wr_dur_i = 16'(cd);
    end
    build(len, LOOPS);
    len_i = 3'(len); start_i = 1'b1;
    step();
    start_i = 1'b0; wr_en_i = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      chk(nm, 64'({div_k_o, div_en_o, busy_o, done_o}),
          64'({exp_q[c].k, exp_q[c].en, exp_q[c].busy, exp_q[c].done}));
      if (exp_q[c].idx >= 0) chk({nm, " idx"}, 64'(idx_o), 64'(exp_q[c].idx));
      if (c == wr_at) begin
        wr_en_i = 1'b1; wr_addr_i = 2'd0; wr_k_i = 32'd99; wr_dur_i = 16'd3;
      end
      step();
      wr_en_i = 1'b0;
    end
`ifdef TFD_SEQ_LOOP_EN
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk({nm, " stop"}, 64'({div_k_o, div_en_o, busy_o, done_o, idx_o}), 64'd0);
`endif
  endtask
  initial begin
    vt[0] = '{10, 2, 20, 1, 2, 15, 15, 10, 10, 1};
    vt[1] = '{0, 3, 0, 0, 1, 14, 14, 5, 0, 0};
    vt[2] = '{5, 0, 7, 1, 2, 7, 7, 3, 7, 1};
    vt[3] = '{1, 1, 1, 1, 0, 2, 2, 1, 0, 0};
    step();
    step();
    chk("reset", 64'({div_k_o, div_en_o, busy_o, done_o, idx_o}), 64'd0);
    rst = 1'b0;
    step();
`ifndef TFD_SEQ_LOOP_EN
    foreach (vt[v]) begin
      wr(0, vt[v].k0, vt[v].d0);
      wr(1, vt[v].k1, vt[v].d1);
      len_i = 3'(vt[v].len); start_i = 1'b1;
      step();
      start_i = 1'b0;
      bn = 0; da = -1;
      for (int t = 1; t <= 20; t++) begin
        if (busy_o) bn++;
        if (done_o) da = t;
        if (t == vt[v].probe_t)
          chk("vec probe", 64'({div_k_o, div_en_o}), 64'({32'(vt[v].probe_k), 1'(vt[v].probe_en)}));
        step();
      end
      chk("vec busy cycles", 64'(bn), 64'(vt[v].busy_n));
      chk("vec done cycle", 64'(da), 64'(vt[v].done_at));
    end
`endif
    wr(0, 10, 2);
    wr(1, 20, 1);
    len_i = 3'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step(); step();
    chk("stop pre", 64'({div_k_o, div_en_o}), 64'({32'd10, 1'b1}));
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("stop idle", 64'({div_k_o, div_en_o, busy_o, done_o, idx_o}), 64'd0);
    dn = 0;
    for (int t = 0; t < 15; t++) begin
      if (done_o || busy_o) dn++;
      step();
    end
    chk("stop quiet", 64'(dn), 64'd0);
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    chk("start+stop", 64'(busy_o), 64'd0);
    step();
    chk("start+stop later", 64'(busy_o), 64'd0);
    run("s1", 2, -1, 1'b0, 0, 0, 0);
    run("busy write", 2, 2, 1'b0, 0, 0, 0);
    run("replay", 2, -1, 1'b0, 0, 0, 0);
    len_i = 3'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("async rst", 64'({div_k_o, div_en_o, busy_o, done_o, idx_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run("after rst", 2, -1, 1'b0, 0, 0, 0);
    run("co-write", 1, -1, 1'b1, 0, 3, 1);
    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < DEPTH; a++)
        wr(a, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60), $urandom_range(0, 3));
`ifdef TFD_SEQ_LOOP_EN
      ln = int'($urandom_range(1, 4));
`else
      ln = int'($urandom_range(0, 4));
`endif
      run("rand", ln, -1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          $urandom_range(1, 9), $urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
